// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic bit cfg_ok(int unsigned width, int unsigned chunk);
    return (chunk != 0) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  // Counter width for n steps; at least one bit even when n == 1.
  function automatic int unsigned cnt_w(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_iter_if.sv
// Request/response bundle between a requester and the iterative multiplier.
interface mult_iter_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/mult_iter_fsm.sv
// Sequencer: walks k over all chunk pairs, then one sign-fix cycle.
module mult_iter_fsm
  import mult_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned IW  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          clr_prod_o,
  output logic          upd_prod_o,
  output logic          neg_prod_o,
  output logic [IW-1:0] i_o,
  output logic [IW-1:0] j_o
);

  localparam int unsigned N  = NCH * NCH;
  localparam int unsigned KW = cnt_w(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_NCH  = KW'(NCH);

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clr_prod_o = 1'b0;
    upd_prod_o = 1'b0;
    neg_prod_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = MUL;
          k_d        = '0;
          busy_d     = 1'b1;
          clr_prod_o = 1'b1;
        end
      end
      MUL: begin
        upd_prod_o = 1'b1;
        if (k_q == K_LAST) begin
          state_d = FIX;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      FIX: begin
        neg_prod_o = 1'b1;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // k enumerates chunk pairs row-major: i selects the a chunk, j the b chunk.
  assign i_o    = IW'(k_q / K_NCH);
  assign j_o    = IW'(k_q % K_NCH);
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/mult_iter.sv
// Iterative WIDTH x WIDTH multiplier, one CHUNK x CHUNK partial product per cycle.
module mult_iter
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 16
) (
  input  logic       clk,
  input  logic       reset,
  mult_iter_if.slave bus
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned IW  = cnt_w(NCH);
  localparam int unsigned PW  = 2 * WIDTH;

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("mult_iter: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             clr_prod, upd_prod, neg_prod;
  logic [IW-1:0]    sel_i, sel_j;

  logic [WIDTH-1:0] amag_q, bmag_q;
  logic             neg_q;
  logic [PW-1:0]    prod_q, prod_d;

  logic [CHUNK-1:0]   a_chunk, b_chunk;
  logic [2*CHUNK-1:0] pp;
  logic [PW-1:0]      pp_shift;

  mult_iter_fsm #(
    .NCH (NCH),
    .IW  (IW)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .start_i    (bus.start),
    .busy_o     (bus.busy),
    .done_o     (bus.done),
    .clr_prod_o (clr_prod),
    .upd_prod_o (upd_prod),
    .neg_prod_o (neg_prod),
    .i_o        (sel_i),
    .j_o        (sel_j)
  );

  // Two's-complement magnitude; the most negative value maps onto itself, read unsigned.
  function automatic logic [WIDTH-1:0] mag(logic [WIDTH-1:0] x, logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  always_comb begin
    a_chunk  = amag_q[sel_i*CHUNK +: CHUNK];
    b_chunk  = bmag_q[sel_j*CHUNK +: CHUNK];
    pp       = (2*CHUNK)'(a_chunk) * (2*CHUNK)'(b_chunk);
    pp_shift = PW'(pp) << ((32'(sel_i) + 32'(sel_j)) * CHUNK);
  end

  always_comb begin
    prod_d = prod_q;
    if (clr_prod) begin
      prod_d = '0;
    end else if (upd_prod) begin
      prod_d = prod_q + pp_shift;
    end else if (neg_prod && neg_q) begin
      prod_d = -prod_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      amag_q <= '0;
      bmag_q <= '0;
      neg_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      if (clr_prod) begin
        amag_q <= mag(bus.a, bus.is_signed);
        bmag_q <= mag(bus.b, bus.is_signed);
        neg_q  <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      end
      prod_q <= prod_d;
    end
  end

  assign bus.product = prod_q;

  a_done_not_busy: assert property (
    @(posedge clk) disable iff (!reset) bus.done |-> !bus.busy
  );

endmodule

// File: doc/mult_iter.md
# mult_iter

Parametrised iterative multiplier, the next generation of the team's 32x32 iterative multiplier. It computes a WIDTH x WIDTH product one CHUNK x CHUNK partial product per cycle and supports signed or unsigned operation per request. It latches its operands at start and signals completion with a done pulse. It sits behind any requester that drives a start/busy handshake, and it drops in wherever the fixed 32x32 multiplier was used.

## Interface
- WIDTH, default 32: operand width; must be a multiple of CHUNK.
- CHUNK, default 16: partial-product width per cycle; NCH = WIDTH/CHUNK, N = NCH*NCH partial cycles.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2*WIDTH  result; held until the next accepted start.

## Operation
- States: IDLE, MUL, FIX.
- IDLE, start=1:
  - Latch |a| and |b| as WIDTH-bit magnitudes. In signed mode, -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits unsigned.
  - Latch neg = is_signed & (a[MSB] ^ b[MSB]).
  - Clear product; clear counter k; go to MUL.
- MUL, each cycle:
  - i = k / NCH, j = k mod NCH.
  - product += (amag chunk i * bmag chunk j) << ((i+j)*CHUNK).
  - Accumulate in 2*WIDTH bits; a carry out of 2*WIDTH cannot occur.
  - At k = N-1 go to FIX; otherwise k++.
- FIX, one cycle:
  - If neg, product = -product (2*WIDTH-bit two's complement); otherwise hold.
  - Assert done; go to IDLE.
- start while busy is ignored; operands and mode are not re-sampled.
- start in the cycle done is high is accepted normally, so back-to-back operation works.
- Unsigned mode: a and b are treated as raw magnitudes and neg = 0.
- Zero operand: the result is 0 and is never negated to a nonzero value, because -0 = 0.

## Timing
- Reset (async, reset=0): state IDLE, busy=0, done=0, product=0, k=0, operand registers 0. Reset mid-operation aborts the operation with no done.
- Edge 0 accepts start. busy is high from after edge 0 until after edge N+1, i.e. for N+1 cycles.
- Edges 1..N perform the N accumulations. Edge N+1 performs FIX.
- After edge N+1: busy=0, done=1 for exactly one cycle, product final.
- Latency from the accepting edge to done is N+1 cycles: 5 for 32/16, 17 for 32/8.
- product shows intermediate accumulations during busy and is valid only from done onward.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package mult_pkg:
  - state enum (IDLE, MUL, FIX).
  - compile-time checks that WIDTH % CHUNK == 0 and CHUNK <= WIDTH.
  - constant function for the counter width, $clog2(N), with a minimum of 1.
- Sub-module mult_iter_fsm owns the state register, counter k, busy, done, and datapath controls (clr_prod, upd_prod, neg_prod, chunk selects i/j).
- The top level holds the operand/magnitude registers, chunk muxes, CHUNK x CHUNK multiplier, shifter and accumulator.

## Test plan
- WIDTH=32, CHUNK=16, unsigned, a=b=0xFFFFFFFF -> product 0xFFFFFFFE00000001; busy high for 5 cycles; single done pulse.
- Signed, a=-3, b=5 -> 0xFFFFFFFFFFFFFFF1. Signed, a=b=0x80000000 -> 0x4000000000000000. Signed, a=b=-1 -> 1.
- Signed, a=0, b=0x80000000 -> 0. Unsigned, a=0x80000000, b=2 -> 0x0000000100000000.
- Start with a=7, b=6, then pulse start with a=9, b=9 while busy -> product 42, only one done, busy length unchanged. New start in the done cycle -> accepted, with correct second result.
- Drive reset low at cycle 3 of an operation -> busy, done and product go 0 immediately; no done afterwards; the next start computes correctly.
- WIDTH=32, CHUNK=8: 1000 random signed and unsigned pairs -> match the reference model; latency 17 each.
